// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption core. One inverse round per clock. The forward key
// expansion runs once per key load and keeps only rk10; each block then walks the
// key schedule backwards on the fly, so no round-key storage is needed.

package aes_gf_pkg;

  // GF(2^8) multiply-by-two with the 0x1b reduction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add over the bits of b
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? aa : 8'h00);
      aa  = xtime(aa);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] mul_9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] mul_b(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] mul_d(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] mul_e(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  // Round constant for forward round idx (1..10)
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Byte n of the block sits at bits [127-8n -: 8]; row = n%4, column = n/4
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3);
      o[119-32*c -: 8] = mul_9(a0) ^ mul_e(a1) ^ mul_b(a2) ^ mul_d(a3);
      o[111-32*c -: 8] = mul_d(a0) ^ mul_9(a1) ^ mul_e(a2) ^ mul_b(a3);
      o[103-32*c -: 8] = mul_b(a0) ^ mul_d(a1) ^ mul_9(a2) ^ mul_e(a3);
    end
    return o;
  endfunction

endpackage

// Forward S-box: inverse in GF(2^8) followed by the affine map
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import aes_gf_pkg::*;
  logic [7:0] inv_s;

  // Field inverse then affine transform with constant 0x63
  always_comb begin
    inv_s = ginv(a);
    y = inv_s ^ rotl8(inv_s, 32'd1) ^ rotl8(inv_s, 32'd2) ^ rotl8(inv_s, 32'd3)
        ^ rotl8(inv_s, 32'd4) ^ 8'h63;
  end
endmodule

// Inverse S-box: inverse affine map followed by the field inverse
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import aes_gf_pkg::*;
  logic [7:0] aff_s;

  // Undo the affine transform, then invert in GF(2^8)
  always_comb begin
    aff_s = rotl8(a, 32'd1) ^ rotl8(a, 32'd3) ^ rotl8(a, 32'd6) ^ 8'h05;
    y = ginv(aff_s);
  end
endmodule

module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);
  import aes_gf_pkg::*;

  localparam logic [3:0] LAST_RND = 4'(NR);

  typedef enum logic [2:0] {
    ST_NOKEY  = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_READY  = 3'd2,
    ST_ROUND  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t         state_r, state_s;
  logic [127:0]   rk_r, rk_s;      // expansion working key, then rk10
  logic [127:0]   wk_r, wk_s;      // backwards-walking round key during ROUND
  logic [127:0]   s_r, s_s;        // cipher state
  logic [3:0]     cnt_r, cnt_s;
  logic           key_ready_s, out_valid_s, busy_s;
  logic [127:0]   data_out_s;

  logic [31:0]    ks_word_s, ks_rot_s, ks_sub_s;
  logic [3:0]     rcon_idx_s;
  logic [127:0]   fwd_key_s, inv_key_s;
  logic [127:0]   shifted_s, isb_s, ark_s, round_out_s;

  // Key-load has priority over a same-cycle ciphertext offer
  assign in_ready = (state_r == ST_READY) && !key_load;

  // The four key-schedule S-boxes are shared: forward word during KEYEXP,
  // reconstructed w[i-1] during ROUND
  always_comb begin
    if (state_r == ST_ROUND) begin
      ks_word_s  = wk_r[31:0] ^ wk_r[63:32];
      rcon_idx_s = cnt_r + 4'd1;
    end else begin
      ks_word_s  = rk_r[31:0];
      rcon_idx_s = cnt_r;
    end
    ks_rot_s = {ks_word_s[23:0], ks_word_s[31:24]};
  end

  for (genvar j = 0; j < 4; j++) begin : g_ksb
    sbox u_sbox (.a(ks_rot_s[31-8*j -: 8]), .y(ks_sub_s[31-8*j -: 8]));
  end

  // Forward schedule step rk(cnt-1) -> rk(cnt) and inverse step rk(cnt+1) -> rk(cnt)
  always_comb begin
    fwd_key_s[127:96] = rk_r[127:96] ^ ks_sub_s ^ {rcon(rcon_idx_s), 24'h000000};
    fwd_key_s[95:64]  = rk_r[95:64] ^ fwd_key_s[127:96];
    fwd_key_s[63:32]  = rk_r[63:32] ^ fwd_key_s[95:64];
    fwd_key_s[31:0]   = rk_r[31:0]  ^ fwd_key_s[63:32];
    inv_key_s[31:0]   = wk_r[31:0]  ^ wk_r[63:32];
    inv_key_s[63:32]  = wk_r[63:32] ^ wk_r[95:64];
    inv_key_s[95:64]  = wk_r[95:64] ^ wk_r[127:96];
    inv_key_s[127:96] = wk_r[127:96] ^ ks_sub_s ^ {rcon(rcon_idx_s), 24'h000000};
  end

  // Row rotation ahead of the sixteen inverse S-boxes
  always_comb begin
    shifted_s = inv_shift_rows(s_r);
  end

  for (genvar i = 0; i < 16; i++) begin : g_isb
    inv_sbox u_inv_sbox (.a(shifted_s[127-8*i -: 8]), .y(isb_s[127-8*i -: 8]));
  end

  // Add the freshly derived round key; the final round skips InvMixColumns
  always_comb begin
    ark_s = isb_s ^ inv_key_s;
    if (cnt_r == 4'd0) begin
      round_out_s = ark_s;
    end else begin
      round_out_s = inv_mix_columns(ark_s);
    end
  end

  // Next-state and next-register values for the control FSM and datapath
  always_comb begin
    state_s     = state_r;
    rk_s        = rk_r;
    wk_s        = wk_r;
    s_s         = s_r;
    cnt_s       = cnt_r;
    key_ready_s = key_ready;
    out_valid_s = out_valid;
    data_out_s  = data_out;
    case (state_r)
      ST_NOKEY: begin
        if (key_load) begin
          rk_s    = key;
          cnt_s   = 4'd1;
          state_s = ST_KEYEXP;
        end else begin
          state_s = ST_NOKEY;
        end
      end
      ST_KEYEXP: begin
        rk_s = fwd_key_s;
        if (cnt_r == LAST_RND) begin
          key_ready_s = 1'b1;
          state_s     = ST_READY;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      ST_READY: begin
        if (key_load) begin
          rk_s        = key;
          cnt_s       = 4'd1;
          key_ready_s = 1'b0;
          state_s     = ST_KEYEXP;
        end else if (in_valid) begin
          s_s     = data_in ^ rk_r;
          wk_s    = rk_r;
          cnt_s   = LAST_RND - 4'd1;
          state_s = ST_ROUND;
        end else begin
          state_s = ST_READY;
        end
      end
      ST_ROUND: begin
        wk_s = inv_key_s;
        s_s  = round_out_s;
        if (cnt_r == 4'd0) begin
          data_out_s  = round_out_s;
          out_valid_s = 1'b1;
          state_s     = ST_DONE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          state_s     = ST_READY;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s     = ST_NOKEY;
        key_ready_s = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
    busy_s = (state_s == ST_KEYEXP) || (state_s == ST_ROUND);
  end

  // State and datapath registers; reset discards the key and any block in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_NOKEY;
      rk_r      <= 128'h0;
      wk_r      <= 128'h0;
      s_r       <= 128'h0;
      cnt_r     <= 4'd0;
      key_ready <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      data_out  <= 128'h0;
    end else begin
      state_r   <= state_s;
      rk_r      <= rk_s;
      wk_r      <= wk_s;
      s_r       <= s_s;
      cnt_r     <= cnt_s;
      key_ready <= key_ready_s;
      out_valid <= out_valid_s;
      busy      <= busy_s;
      data_out  <= data_out_s;
    end
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative AES-128 decryption core: one inverse round per clock, with valid/ready handshakes on input and output.
- It is the receive-side counterpart of the team's pipelined encryption core and uses the same 128-bit byte ordering, so encryption output feeds decryption input directly.
- A forward key expansion runs once per key load and keeps the round-10 key. The inverse key schedule then generates round keys backwards on the fly, so no round-key RAM is needed.

Parameters:
- NR, 10, number of rounds; fixed for AES-128, and any other value is unsupported.

Ports:
- clk        in   1    rising-edge clock
- rst_n      in   1    asynchronous active-low reset
- key_load   in   1    pulse: latch key and start expansion
- key        in   128  cipher key; bit 127 = FIPS-197 byte 0
- key_ready  out  1    expanded key valid; decryption allowed
- in_valid   in   1    ciphertext valid
- in_ready   out  1    core can accept ciphertext
- data_in    in   128  ciphertext; bit 127 = byte 0
- out_valid  out  1    plaintext valid
- out_ready  in   1    sink accepts plaintext
- data_out   out  128  plaintext; held stable while out_valid=1
- busy       out  1    high in KEYEXP or ROUND

Behaviour:
- Reset (async, rst_n=0):
  - state=NOKEY; key_ready, in_ready, out_valid, busy = 0; data_out=0.
  - Internal state register, round keys and counter = 0.
  - Reset mid-operation aborts the block or expansion and discards the key.
- States: NOKEY, KEYEXP, READY, ROUND, DONE.
- NOKEY: key_load=1 latches key as rk0, sets cnt=1, goes to KEYEXP.
- KEYEXP:
  - Each cycle computes rk(cnt) from rk(cnt-1) with the forward schedule (SubWord/RotWord/Rcon).
  - After 10 cycles (cnt=10) it stores rk10, sets key_ready=1 and goes to READY.
  - key_ready=0 throughout.
- READY:
  - in_ready = !key_load (combinational); key_load has priority over in_valid in the same cycle.
  - key_load=1: key_ready falls next edge, goes to KEYEXP.
  - in_valid and in_ready both high: s <= data_in ^ rk10, wk <= rk10, cnt <= 9, goes to ROUND.
- ROUND:
  - Each cycle computes wk' = rk(cnt) from wk with the inverse schedule: w[i-4] = w[i] ^ t, where t = SubWord(RotWord(w[i-1])) ^ Rcon for i mod 4 = 0, else w[i-1].
  - Each cycle updates s <= InvMixColumns(InvSubBytes(InvShiftRows(s)) ^ wk'); InvMixColumns is omitted when cnt=0.
  - cnt decrements each cycle; at cnt=0 it loads data_out, sets out_valid=1 and goes to DONE.
  - Exactly 10 ROUND cycles, so out_valid rises on the 10th rising edge after the accept edge.
- DONE:
  - data_out and out_valid are held until out_ready=1.
  - On out_ready=1, out_valid clears at that edge and the state goes to READY.
  - Minimum accept-to-accept period is 12 cycles.
- key_load during KEYEXP, ROUND or DONE is ignored; the current operation completes with the old key.
- in_valid while not READY: in_ready=0 and nothing is captured.
- The source must hold data_in stable until the handshake.
- rk10 persists across blocks, so later blocks need no re-expansion.
- Rcon values:
  - Forward sequence: 01,02,04,08,10,20,40,80,1b,36.
  - Inverse schedule uses the reverse order.
- GF(2^8) multiplies by 09, 0b, 0d, 0e use xtime with the 0x1b reduction.
- Inverse S-box is a leaf module inv_sbox, instantiated 16x; key-schedule S-boxes (4x) reuse the existing forward sbox.

Test Plan:
- Reset, then key_load with key 2b7e151628aed2a6abf7158809cf4f3c:
  - key_ready stays 0 for 10 cycles, then rises.
  - Internal rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Same key, data_in 3925841d02dc09fbdc118597196a0b32, out_ready=1:
  - out_valid 10 cycles after accept.
  - data_out = 3243f6a8885a308d313198a2e0370734.
- Key 000102030405060708090a0b0c0d0e0f (rk10 13111d7fe3944a17f307a78b4d2b30c5), data_in 69c4e0d86a7b0430d8cdb78070b4c55a:
  - data_out = 00112233445566778899aabbccddeeff.
- Back-pressure: out_ready=0 for 20 cycles:
  - out_valid and data_out are stable and in_ready=0.
  - After out_ready=1, the second block is accepted and decrypted correctly.
- key_load asserted in ROUND with a new key:
  - Ignored; the current block still yields the old-key plaintext.
- Same-cycle key_load and in_valid in READY:
  - in_ready=0 and re-expansion runs.
- rst_n pulsed low at ROUND cnt=5:
  - All outputs 0 immediately and state NOKEY.
  - in_ready stays 0 until a new key_load completes.
